fc_engine: RTL and testbench

- Parametrised fully-connected layer engine for the FER inference pipeline; sits after the last pooling stage and replaces the fixed FC stage.
- Buffers one flattened feature vector of IN_LEN IEEE-754 single values.
- Computes OUT_LEN neuron outputs as y[n] = sum(x[i]*w[n][i]) + b[n], with optional ReLU.
- Weights and bias are streamed from the parameter memory with valid/ready handshakes; results leave on a back-pressurable stream.

---
 rtl/fc_pkg.sv | 23 ++
 rtl/fc_mac_lane.sv | 89 ++++++++
 rtl/fc_engine.sv | 123 ++++++++++++
 tb/tb_fc_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer engine.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_BIAS,
    ST_OUT
  } fc_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam int unsigned FP_SIGN = 31;

  // Never returns less than 1 so single-entry counters still get a bit.
  function automatic int unsigned fc_clog2(input int unsigned value);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fp32 multiply-accumulate lane: acc += a*w per beat, acc += bias on request.
module fc_mac_lane
  import fc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        bias_en,
  input  logic [31:0] a,
  input  logic [31:0] w,
  input  logic [31:0] bias,
  output logic [31:0] acc
);

  // Denormals flush to zero, mantissa is truncated, overflow saturates to Inf.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] prod;
    logic        s;
    int          e;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
    prod = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (prod[47]) begin
      prod = prod >> 24;
      e = e + 1;
    end else begin
      prod = prod >> 23;
    end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), 23'(prod)};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] p, input logic [31:0] q);
    logic [31:0] x;
    logic [31:0] y;
    logic [26:0] mx;
    logic [26:0] my;
    logic [26:0] sum;
    int          e;
    int          d;
    if (p[30:23] == 8'd0) return q;
    if (q[30:23] == 8'd0) return p;
    if (p[30:0] >= q[30:0]) begin
      x = p;
      y = q;
    end else begin
      x = q;
      y = p;
    end
    // Hidden bit sits at 25; two extra low bits keep alignment precision.
    mx = {2'b01, x[22:0], 2'b00};
    my = {2'b01, y[22:0], 2'b00};
    d  = int'(x[30:23]) - int'(y[30:23]);
    my = (d > 26) ? '0 : (my >> d);
    e  = int'(x[30:23]);
    sum = (x[31] == y[31]) ? (mx + my) : (mx - my);
    if (sum == '0) return FP_ZERO;
    if (sum[26]) begin
      sum = sum >> 1;
      e = e + 1;
    end else begin
      for (int unsigned k = 0; k < 26; k++) begin
        if (!sum[25]) begin
          sum = sum << 1;
          e = e - 1;
        end
      end
    end
    if (e <= 0) return {x[31], 31'd0};
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], 8'(e), 23'(sum >> 2)};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= FP_ZERO;
    end else if (clear) begin
      acc <= FP_ZERO;
    end else if (en) begin
      acc <= fp_add(acc, fp_mul(a, w));
    end else if (bias_en) begin
      acc <= fp_add(acc, bias);
    end
  end

endmodule

// File: rtl/fc_engine.sv
// Fully-connected layer engine: buffers one feature vector, then streams
// weights/bias per neuron and emits y[n] = sum(x[i]*w[n][i]) + b[n].
module fc_engine
  import fc_pkg::*;
#(
  parameter int BIT     = 32,
  parameter int IN_LEN  = 32,
  parameter int OUT_LEN = 10,
  parameter int RELU    = 0
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         start,
  input  logic [BIT-1:0]               in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIT-1:0]               w_data,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [BIT-1:0]               b_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  output logic [BIT-1:0]               out_data,
  output logic [fc_clog2(OUT_LEN)-1:0] out_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned IW = fc_clog2(IN_LEN);
  localparam int unsigned NW = fc_clog2(OUT_LEN);
  localparam logic [IW-1:0] I_LAST = IW'(IN_LEN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(OUT_LEN - 1);

  fc_state_e      state;
  fc_state_e      state_nx;
  logic [IW-1:0]  i;
  logic [NW-1:0]  n;
  logic [BIT-1:0] feat_buf [IN_LEN];
  logic [BIT-1:0] acc;
  logic           lane_clear;
  logic           last_out;

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    w_ready    = 1'b0;
    b_ready    = 1'b0;
    out_valid  = 1'b0;
    lane_clear = 1'b0;
    last_out   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && i == I_LAST) begin
          state_nx   = ST_MAC;
          lane_clear = 1'b1;
        end
      end
      ST_MAC: begin
        w_ready = 1'b1;
        if (w_valid && i == I_LAST) state_nx = ST_BIAS;
      end
      ST_BIAS: begin
        b_ready = 1'b1;
        if (b_valid) state_nx = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (n == N_LAST) begin
            state_nx = ST_IDLE;
            last_out = 1'b1;
          end else begin
            state_nx   = ST_MAC;
            lane_clear = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // i wraps to 0 on its last beat, so it is already cleared for the next phase.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state <= ST_IDLE;
      i     <= '0;
      n     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last_out;
      if ((in_ready && in_valid) || (w_ready && w_valid))
        i <= (i == I_LAST) ? '0 : i + IW'(1);
      if (out_valid && out_ready)
        n <= (n == N_LAST) ? '0 : n + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) feat_buf[i] <= in_data;
  end

  fc_mac_lane u_lane (
    .clk     (clk),
    .rst     (rst_),
    .clear   (lane_clear),
    .en      (w_ready && w_valid),
    .bias_en (b_ready && b_valid),
    .a       (feat_buf[i]),
    .w       (w_data),
    .bias    (b_data),
    .acc     (acc)
  );

  assign out_data = (RELU != 0 && acc[FP_SIGN]) ? FP_ZERO : acc;
  assign out_idx  = n;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_fc_engine.sv
// Directed bench for fc_engine: a RELU=0 and a RELU=1 instance run in lockstep.
module tb_fc_engine;

  localparam logic [31:0] F0  = 32'h0000_0000;
  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] FH  = 32'h3F00_0000;
  localparam logic [31:0] FM1 = 32'hBF80_0000;
  localparam logic [31:0] FM2 = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        rst_, start;
  logic [31:0] in_data, w_data, b_data;
  logic        in_valid, w_valid, b_valid, out_ready;

  logic        in_ready, w_ready, b_ready, out_valid, busy, done;
  logic [31:0] out_data;
  logic [0:0]  out_idx;
  logic        in_ready_r, w_ready_r, b_ready_r, out_valid_r, busy_r, done_r;
  logic [31:0] out_data_r;
  logic [0:0]  out_idx_r;

  int ncmp = 0, nfail = 0;
  int cyc = 0, wcnt = 0, done_cnt = 0, done_cyc = 0, hs_cyc = -1;
  logic [31:0] xv [4];
  logic [31:0] wv [8];
  logic [31:0] res0 [2];
  logic [31:0] res1 [2];
  logic [0:0]  ridx [2];
  int          wn [2];

  fc_engine #(.BIT(32), .IN_LEN(4), .OUT_LEN(2), .RELU(0)) dut (
    .clk(clk), .rst_(rst_), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  fc_engine #(.BIT(32), .IN_LEN(4), .OUT_LEN(2), .RELU(1)) dut_relu (
    .clk(clk), .rst_(rst_), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_r),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready_r),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready_r),
    .out_data(out_data_r), .out_idx(out_idx_r), .out_valid(out_valid_r), .out_ready(out_ready),
    .busy(busy_r), .done(done_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (w_valid && w_ready) wcnt = wcnt + 1;
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, want completion");
    $fatal(1, "watchdog");
  end

  // which: 0 = feature, 1 = weight, 2 = bias
  task automatic send(input int which, input logic [31:0] d, input bit bubble);
    bit f;
    for (int c = 0; c < 200; c++) begin
      case (which)
        0: begin
          in_data  = d;
          in_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
          f = in_valid && in_ready;
          if (f && hs_cyc < 0) hs_cyc = cyc;
        end
        1: begin
          w_data  = d;
          w_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
          f = w_valid && w_ready;
        end
        default: begin
          b_data  = d;
          b_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
          f = b_valid && b_ready;
        end
      endcase
      @(posedge clk); #1;
      if (f) begin
        in_valid = 1'b0; w_valid = 1'b0; b_valid = 1'b0;
        return;
      end
    end
    $display("FAIL send%0d_timeout: got no handshake, want one within 200 cycles", which);
    ncmp++; nfail++;
    in_valid = 1'b0; w_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic take(output logic [31:0] d0, output logic [31:0] d1, output logic [0:0] ix);
    bit f;
    d0 = '0; d1 = '0; ix = '0;
    for (int c = 0; c < 200; c++) begin
      out_ready = 1'b1;
      f = out_valid && out_ready;
      if (f) begin
        d0 = out_data; d1 = out_data_r; ix = out_idx;
      end
      @(posedge clk); #1;
      if (f) begin
        out_ready = 1'b0;
        return;
      end
    end
    out_ready = 1'b0;
    $display("FAIL take_timeout: got no out handshake, want one within 200 cycles");
    ncmp++; nfail++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] b1, input bit bubble);
    int w0;
    hs_cyc = -1;
    pulse_start();
    for (int k = 0; k < 4; k++) send(0, xv[k], bubble);
    for (int nn = 0; nn < 2; nn++) begin
      w0 = wcnt;
      for (int k = 0; k < 4; k++) send(1, wv[nn*4+k], bubble);
      send(2, (nn == 0) ? FH : b1, bubble);
      wn[nn] = wcnt - w0;
      take(res0[nn], res1[nn], ridx[nn]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    ncmp++;
    if ({busy, in_ready, w_ready, b_ready, out_valid, done} !== 6'b0) begin
      $display("FAIL %s_ctrl: got %b, want 000000", tag,
               {busy, in_ready, w_ready, b_ready, out_valid, done});
      nfail++;
    end
    ncmp++;
    if (out_data !== F0) begin
      $display("FAIL %s_data: got %h, want %h", tag, out_data, F0); nfail++;
    end
    ncmp++;
    if (out_idx !== 1'b0) begin
      $display("FAIL %s_idx: got %0d, want 0", tag, out_idx); nfail++;
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b1; start = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; w_valid = 1'b0; b_valid = 1'b0;
    in_data = '0; w_data = '0; b_data = '0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc;
    dc = done_cnt;
    run_frame(F0, 1'b0);
    ncmp++; if (res0[0] !== F3) begin $display("FAIL basic_y0: got %h, want %h", res0[0], F3); nfail++; end
    ncmp++; if (ridx[0] !== 1'b0) begin $display("FAIL basic_idx0: got %0d, want 0", ridx[0]); nfail++; end
    ncmp++; if (res0[1] !== F1) begin $display("FAIL basic_y1: got %h, want %h", res0[1], F1); nfail++; end
    ncmp++; if (ridx[1] !== 1'b1) begin $display("FAIL basic_idx1: got %0d, want 1", ridx[1]); nfail++; end
    ncmp++; if (done !== 1'b1) begin $display("FAIL basic_done_hi: got %b, want 1", done); nfail++; end
    ncmp++; if (busy !== 1'b0) begin $display("FAIL basic_busy: got %b, want 0", busy); nfail++; end
    @(posedge clk); #1;
    ncmp++; if (done !== 1'b0) begin $display("FAIL basic_done_lo: got %b, want 0", done); nfail++; end
    ncmp++; if (done_cnt - dc !== 1) begin $display("FAIL basic_done_cnt: got %0d, want 1", done_cnt - dc); nfail++; end
    ncmp++; if (done_cyc - hs_cyc !== 16) begin
      $display("FAIL basic_latency: got %0d, want 16", done_cyc - hs_cyc); nfail++;
    end
  endtask

  task automatic test_relu();
    run_frame(FM2, 1'b0);
    ncmp++; if (res1[0] !== F3) begin $display("FAIL relu_y0: got %h, want %h", res1[0], F3); nfail++; end
    ncmp++; if (res1[1] !== F0) begin $display("FAIL relu_y1: got %h, want %h", res1[1], F0); nfail++; end
    ncmp++; if (res0[1] !== FM1) begin $display("FAIL norelu_y1: got %h, want %h", res0[1], FM1); nfail++; end
    ncmp++; if (ridx[1] !== 1'b1) begin $display("FAIL relu_idx1: got %0d, want 1", ridx[1]); nfail++; end
  endtask

  task automatic test_bubbles();
    run_frame(F0, 1'b1);
    ncmp++; if (res0[0] !== F3) begin $display("FAIL bubble_y0: got %h, want %h", res0[0], F3); nfail++; end
    ncmp++; if (res0[1] !== F1) begin $display("FAIL bubble_y1: got %h, want %h", res0[1], F1); nfail++; end
    ncmp++; if (ridx[1] !== 1'b1) begin $display("FAIL bubble_idx1: got %0d, want 1", ridx[1]); nfail++; end
    ncmp++; if (wn[0] !== 4) begin $display("FAIL bubble_wcnt0: got %0d, want 4", wn[0]); nfail++; end
    ncmp++; if (wn[1] !== 4) begin $display("FAIL bubble_wcnt1: got %0d, want 4", wn[1]); nfail++; end
  endtask

  task automatic test_backpressure();
    int w0;
    logic [31:0] d0, d1;
    logic [0:0]  ix;
    pulse_start();
    for (int k = 0; k < 4; k++) send(0, xv[k], 1'b0);
    for (int k = 0; k < 4; k++) send(1, wv[k], 1'b0);
    send(2, FH, 1'b0);
    w0 = wcnt;
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b0; w_valid = 1'b1; w_data = F2;
      ncmp++; if (out_valid !== 1'b1) begin $display("FAIL stall_valid: got %b, want 1", out_valid); nfail++; end
      ncmp++; if (out_data !== F3) begin $display("FAIL stall_data: got %h, want %h", out_data, F3); nfail++; end
      ncmp++; if (out_idx !== 1'b0) begin $display("FAIL stall_idx: got %0d, want 0", out_idx); nfail++; end
      ncmp++; if (w_ready !== 1'b0) begin $display("FAIL stall_wready: got %b, want 0", w_ready); nfail++; end
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    ncmp++; if (wcnt - w0 !== 0) begin $display("FAIL stall_wcnt: got %0d, want 0", wcnt - w0); nfail++; end
    take(d0, d1, ix);
    ncmp++; if (d0 !== F3) begin $display("FAIL stall_y0: got %h, want %h", d0, F3); nfail++; end
    for (int k = 4; k < 8; k++) send(1, wv[k], 1'b0);
    send(2, F0, 1'b0);
    take(d0, d1, ix);
    ncmp++; if (d0 !== F1) begin $display("FAIL stall_y1: got %h, want %h", d0, F1); nfail++; end
    ncmp++; if (ix !== 1'b1) begin $display("FAIL stall_idx1: got %0d, want 1", ix); nfail++; end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d0, d1;
    logic [0:0]  ix;
    pulse_start();
    for (int k = 0; k < 4; k++) send(0, xv[k], 1'b0);
    for (int k = 0; k < 4; k++) send(1, wv[k], 1'b0);
    send(2, FH, 1'b0);
    take(d0, d1, ix);
    send(1, wv[4], 1'b0);
    send(1, wv[5], 1'b0);
    rst_ = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst_ = 1'b0;
    @(posedge clk); #1;
    run_frame(F0, 1'b0);
    ncmp++; if (res0[0] !== F3) begin $display("FAIL midrst_y0: got %h, want %h", res0[0], F3); nfail++; end
    ncmp++; if (res0[1] !== F1) begin $display("FAIL midrst_y1: got %h, want %h", res0[1], F1); nfail++; end
  endtask

  task automatic test_start_ignored();
    logic [31:0] d0, d1;
    logic [0:0]  ix;
    pulse_start();
    send(0, xv[0], 1'b0);
    send(0, xv[1], 1'b0);
    pulse_start();
    ncmp++; if ({busy, in_ready} !== 2'b11) begin $display("FAIL start_load: got %b, want 11", {busy, in_ready}); nfail++; end
    send(0, xv[2], 1'b0);
    send(0, xv[3], 1'b0);
    ncmp++; if (w_ready !== 1'b1) begin $display("FAIL start_load_cnt: got w_ready %b, want 1", w_ready); nfail++; end
    send(1, wv[0], 1'b0);
    send(1, wv[1], 1'b0);
    pulse_start();
    ncmp++; if ({w_ready, in_ready} !== 2'b10) begin $display("FAIL start_mac: got %b, want 10", {w_ready, in_ready}); nfail++; end
    send(1, wv[2], 1'b0);
    send(1, wv[3], 1'b0);
    ncmp++; if (b_ready !== 1'b1) begin $display("FAIL start_mac_cnt: got b_ready %b, want 1", b_ready); nfail++; end
    send(2, FH, 1'b0);
    take(d0, d1, ix);
    ncmp++; if (d0 !== F3) begin $display("FAIL start_y0: got %h, want %h", d0, F3); nfail++; end
    for (int k = 4; k < 8; k++) send(1, wv[k], 1'b0);
    send(2, F0, 1'b0);
    take(d0, d1, ix);
    ncmp++; if (d0 !== F1) begin $display("FAIL start_y1: got %h, want %h", d0, F1); nfail++; end
  endtask

  initial begin
    xv[0] = F1; xv[1] = F2; xv[2] = FH; xv[3] = FM1;
    wv[0] = F1; wv[1] = F1; wv[2] = F1; wv[3] = F1;
    wv[4] = F2; wv[5] = F0; wv[6] = F0; wv[7] = F1;
    test_reset();
    test_basic();
    test_relu();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
